// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - registered N-way select mux with skid buffer and sticky range error
module mux_pipe_n #(
    parameter int WIDTH = 32,
    parameter int N     = 7,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic [SEL_W-1:0]   sel_out,
    output logic               err,
    input  logic               err_clr
);

    logic             or_valid_q, or_valid_d;
    logic [WIDTH-1:0] or_data_q,  or_data_d;
    logic [SEL_W-1:0] or_sel_q,   or_sel_d;
    logic             sk_valid_q, sk_valid_d;
    logic [WIDTH-1:0] sk_data_q,  sk_data_d;
    logic [SEL_W-1:0] sk_sel_q,   sk_sel_d;
    logic             err_q,      err_d;

    logic             accept;
    logic             or_free;
    logic             sel_oor;
    logic [WIDTH-1:0] cap_data;

    assign accept  = in_valid & in_ready;
    assign or_free = ~or_valid_q | out_ready;
    assign sel_oor = (32'(sel) >= 32'(N));

    // Out-of-range selects match no channel and therefore capture zero.
    always_comb begin
        cap_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_sel_d   = or_sel_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_sel_d   = sk_sel_q;
        if (or_free) begin
            // The skid entry is older than any new beat, so it refills OR first.
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_data_d  = sk_data_q;
                or_sel_d   = sk_sel_q;
                sk_valid_d = 1'b0;
            end else if (accept) begin
                or_valid_d = 1'b1;
                or_data_d  = cap_data;
                or_sel_d   = sel;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sk_valid_d = 1'b1;
            sk_data_d  = cap_data;
            sk_sel_d   = sel;
        end
    end

    always_comb begin
        err_d = err_q;
        if (accept && sel_oor) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_sel_q   <= '0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_sel_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_sel_q   <= or_sel_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_sel_q   <= sk_sel_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = ~sk_valid_q;
    assign out_valid = or_valid_q;
    assign data_out  = or_data_q;
    assign sel_out   = or_sel_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - directed and random bench for mux_pipe_n against a queue model
module tb_mux_pipe_n;

    logic         clk;
    logic         rst_n;

    logic         a_iv, a_ir, a_ov, a_or, a_err, a_clr;
    logic [2:0]   a_sel, a_so;
    logic [223:0] a_din;
    logic [31:0]  a_dout;

    logic         b_iv, b_ir, b_ov, b_or, b_err, b_clr;
    logic [1:0]   b_sel, b_so;
    logic [23:0]  b_din;
    logic [7:0]   b_dout;

    logic [31:0]  cha [7];
    logic [7:0]   chb [3];
    logic [39:0]  qa [$];
    logic [39:0]  qb [$];
    bit           ea, eb;
    int           errors;
    int           checks;

    mux_pipe_n #(.WIDTH(32), .N(7), .SEL_W(3)) u_a (
        .clk(clk), .reset_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir), .sel(a_sel), .data_in(a_din),
        .out_valid(a_ov), .out_ready(a_or), .data_out(a_dout), .sel_out(a_so),
        .err(a_err), .err_clr(a_clr)
    );

    mux_pipe_n #(.WIDTH(8), .N(3), .SEL_W(2)) u_b (
        .clk(clk), .reset_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .sel(b_sel), .data_in(b_din),
        .out_valid(b_ov), .out_ready(b_or), .data_out(b_dout), .sel_out(b_so),
        .err(b_err), .err_clr(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("a_in_ready", 64'(a_ir), 64'(qa.size() < 2));
        chk("a_out_valid", 64'(a_ov), 64'(qa.size() > 0));
        if (qa.size() > 0) begin
            chk("a_data_out", 64'(a_dout), 64'(qa[0][31:0]));
            chk("a_sel_out", 64'(a_so), 64'(qa[0][39:32]));
        end
        chk("a_err", 64'(a_err), 64'(ea));
        chk("b_in_ready", 64'(b_ir), 64'(qb.size() < 2));
        chk("b_out_valid", 64'(b_ov), 64'(qb.size() > 0));
        if (qb.size() > 0) begin
            chk("b_data_out", 64'(b_dout), 64'(qb[0][7:0]));
            chk("b_sel_out", 64'(b_so), 64'(qb[0][39:32]));
        end
        chk("b_err", 64'(b_err), 64'(eb));
    endtask

    // One clock: drive both units, advance the occupancy model, compare at the falling edge.
    task automatic cyc(input bit aiv, input int as, input bit aor, input bit aclr,
                       input bit biv, input int bs, input bit bor, input bit bclr);
        bit          aacc, apop, bacc, bpop;
        logic [39:0] abeat, bbeat;
        a_iv = aiv; a_sel = as[2:0]; a_or = aor; a_clr = aclr;
        b_iv = biv; b_sel = bs[1:0]; b_or = bor; b_clr = bclr;
        for (int k = 0; k < 7; k++) a_din[k*32 +: 32] = cha[k];
        for (int k = 0; k < 3; k++) b_din[k*8 +: 8] = chb[k];
        aacc = aiv && (qa.size() < 2);
        apop = aor && (qa.size() > 0);
        bacc = biv && (qb.size() < 2);
        bpop = bor && (qb.size() > 0);
        abeat = {as[7:0], 32'd0};
        if (as < 7) abeat[31:0] = cha[as];
        bbeat = {bs[7:0], 32'd0};
        if (bs < 3) bbeat[7:0] = chb[bs];
        @(posedge clk);
        if (apop) void'(qa.pop_front());
        if (aacc) qa.push_back(abeat);
        if (aacc && as >= 7) ea = 1'b1; else if (aclr) ea = 1'b0;
        if (bpop) void'(qb.pop_front());
        if (bacc) qb.push_back(bbeat);
        if (bacc && bs >= 3) eb = 1'b1; else if (bclr) eb = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ca(input bit iv, input int s, input bit ordy, input bit clr);
        cyc(iv, s, ordy, clr, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic cb(input bit iv, input int s, input bit ordy, input bit clr);
        cyc(1'b0, 0, 1'b1, 1'b0, iv, s, ordy, clr);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ea = 1'b0;
        eb = 1'b0;
        rst_n = 1'b0;
        a_iv = 1'b0; a_sel = '0; a_or = 1'b0; a_clr = 1'b0; a_din = '0;
        b_iv = 1'b0; b_sel = '0; b_or = 1'b0; b_clr = 1'b0; b_din = '0;
        for (int k = 0; k < 7; k++) cha[k] = 32'hCAFE0000 | 32'(k);
        for (int k = 0; k < 3; k++) chb[k] = 8'hA0 | 8'(k);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_a_out_valid", 64'(a_ov), 64'd0);
        chk("rst_a_data_out", 64'(a_dout), 64'd0);
        chk("rst_a_sel_out", 64'(a_so), 64'd0);
        chk("rst_a_err", 64'(a_err), 64'd0);
        chk("rst_b_out_valid", 64'(b_ov), 64'd0);
        chk("rst_b_data_out", 64'(b_dout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        // Single beat, one-cycle latency
        ca(1'b1, 2, 1'b1, 1'b0);
        chk("s1_data", 64'(a_dout), 64'h00000000CAFE0002);
        ca(1'b0, 0, 1'b1, 1'b0);

        // Back-to-back stream at full rate
        for (int k = 0; k < 7; k++) cha[k] = 32'(k + 100);
        for (int k = 0; k < 7; k++) ca(1'b1, k, 1'b1, 1'b0);
        ca(1'b0, 0, 1'b1, 1'b0);

        // Backpressure fills both entries, then drains in order
        cha[0] = 32'hAAAA0000;
        cha[1] = 32'hBBBB0001;
        ca(1'b1, 0, 1'b0, 1'b0);
        ca(1'b1, 1, 1'b0, 1'b0);
        ca(1'b1, 3, 1'b0, 1'b0);
        ca(1'b0, 0, 1'b1, 1'b0);
        ca(1'b0, 0, 1'b1, 1'b0);
        ca(1'b0, 0, 1'b1, 1'b0);

        // Out-of-range select and err_clr priority
        ca(1'b1, 7, 1'b1, 1'b0);
        ca(1'b0, 0, 1'b1, 1'b1);
        ca(1'b1, 7, 1'b1, 1'b1);
        ca(1'b0, 0, 1'b1, 1'b1);

        // Asynchronous reset with both entries occupied
        ca(1'b1, 4, 1'b0, 1'b0);
        ca(1'b1, 5, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(a_ov), 64'd0);
        chk("async_rst_in_ready", 64'(a_ir), 64'd1);
        qa.delete();
        qb.delete();
        ea = 1'b0;
        eb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ca(1'b0, 0, 1'b1, 1'b0);
        ca(1'b0, 0, 1'b1, 1'b0);

        // Narrow instance: stream, backpressure, out-of-range sel=3
        for (int k = 0; k < 3; k++) chb[k] = 8'(k + 100);
        for (int k = 0; k < 3; k++) cb(1'b1, k, 1'b1, 1'b0);
        cb(1'b1, 1, 1'b0, 1'b0);
        cb(1'b1, 2, 1'b0, 1'b0);
        cb(1'b0, 0, 1'b1, 1'b0);
        cb(1'b1, 3, 1'b1, 1'b0);
        cb(1'b0, 0, 1'b1, 1'b1);
        cb(1'b1, 3, 1'b1, 1'b1);
        cb(1'b0, 0, 1'b1, 1'b1);

        // Randomised traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 7; k++) cha[k] = $urandom;
            for (int k = 0; k < 3; k++) chb[k] = 8'($urandom);
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
